jh512_nonce_scheduler: RTL and testbench

//  Sequences the fully pipelined JH512 hasher for nonce search: latches one job (chaining state,
//  128-bit data block, nonce range, target) and issues one candidate per clock. Tracks each

---
 rtl/jh512_nonce_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_jh512_nonce_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jh512_nonce_scheduler.sv
// Nonce-search sequencer for a fully pipelined JH512 hasher: issues one candidate per clock,
// tracks candidates through the hasher latency and queues nonces whose hash meets the target.
module jh512_nonce_scheduler #(
  parameter int HASH_LATENCY = 96,
  parameter int NONCE_LSB    = 96,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [1023:0] job_state,
  input  logic [127:0]  job_data,
  input  logic [31:0]   job_start,
  input  logic [31:0]   job_end,
  input  logic [63:0]   job_target,
  input  logic          abort,
  output logic [1023:0] hs_state,
  output logic [127:0]  hs_data,
  input  logic [511:0]  hs_hash,
  output logic          hit_valid,
  input  logic          hit_ready,
  output logic [31:0]   hit_nonce,
  output logic          busy,
  output logic          done,
  output logic [31:0]   issued_cnt,
  output logic [1:0]    dbg_state
);

  localparam int IW = $clog2(HASH_LATENCY + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = ((IW > FW) ? IW : FW) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [31:0]             nonce_q, nonce_d;
  logic [31:0]             end_q, end_d;
  logic [63:0]             target_q, target_d;
  logic [127:0]            template_q, template_d;
  logic [1023:0]           hs_state_q, hs_state_d;
  logic [127:0]            hs_data_q, hs_data_d;
  logic [31:0]             issued_q, issued_d;
  logic [IW-1:0]           inflight_q, inflight_d;
  logic [HASH_LATENCY-1:0] dl_valid_q, dl_valid_d;
  logic [31:0]             retire_nonce_q, retire_nonce_d;
  logic                    done_q, done_d;
  logic [31:0]             fifo_mem_q [FIFO_DEPTH];
  logic [31:0]             fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]           fifo_count_q, fifo_count_d;

  logic                    issue, retire, hit, pop;
  logic [CW-1:0]           occupancy;
  logic [127:0]            data_ins;

  always_comb begin
    state_d        = state_q;
    nonce_d        = nonce_q;
    end_d          = end_q;
    target_d       = target_q;
    template_d     = template_q;
    hs_state_d     = hs_state_q;
    hs_data_d      = hs_data_q;
    issued_d       = issued_q;
    inflight_d     = inflight_q;
    retire_nonce_d = retire_nonce_q;
    done_d         = 1'b0;
    fifo_mem_d     = fifo_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_count_d   = fifo_count_q;

    data_ins                    = template_q;
    data_ins[NONCE_LSB +: 32]   = nonce_q;

    // Queued hits plus in-flight candidates bound the FIFO fill, so it can never overflow.
    occupancy = CW'(fifo_count_q) + CW'(inflight_q);
    issue     = (state_q == S_RUN) && (occupancy < CW'(FIFO_DEPTH));
    retire    = dl_valid_q[HASH_LATENCY-1];
    hit       = retire && (hs_hash[63:0] <= target_q);
    pop       = (fifo_count_q != '0) && hit_ready;

    dl_valid_d = {dl_valid_q[HASH_LATENCY-2:0], issue};

    if (issue && !retire) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!issue && retire) begin
      inflight_d = inflight_q - IW'(1);
    end

    // Candidates retire in issue order with consecutive nonces, so a counter names each one.
    if (retire) begin
      retire_nonce_d = retire_nonce_q + 32'd1;
    end

    if (hit) begin
      fifo_mem_d[wr_ptr_q] = retire_nonce_q;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (hit && !pop) begin
      fifo_count_d = fifo_count_q + FW'(1);
    end else if (!hit && pop) begin
      fifo_count_d = fifo_count_q - FW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          state_d        = S_RUN;
          nonce_d        = job_start;
          end_d          = job_end;
          target_d       = job_target;
          template_d     = job_data;
          hs_state_d     = job_state;
          issued_d       = 32'd0;
          retire_nonce_d = job_start;
        end
      end
      S_RUN: begin
        if (issue) begin
          hs_data_d = data_ins;
          issued_d  = issued_q + 32'd1;
          nonce_d   = nonce_q + 32'd1;
          // ">=" also ends a reversed range after its first nonce and stops before any wrap.
          if (nonce_q >= end_q) begin
            state_d = S_DRAIN;
          end
        end
        if (abort) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      nonce_q        <= '0;
      end_q          <= '0;
      target_q       <= '0;
      template_q     <= '0;
      hs_state_q     <= '0;
      hs_data_q      <= '0;
      issued_q       <= '0;
      inflight_q     <= '0;
      dl_valid_q     <= '0;
      retire_nonce_q <= '0;
      done_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      nonce_q        <= nonce_d;
      end_q          <= end_d;
      target_q       <= target_d;
      template_q     <= template_d;
      hs_state_q     <= hs_state_d;
      hs_data_q      <= hs_data_d;
      issued_q       <= issued_d;
      inflight_q     <= inflight_d;
      dl_valid_q     <= dl_valid_d;
      retire_nonce_q <= retire_nonce_d;
      done_q         <= done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  // Handshakes: a job transfers on job_valid&job_ready, a hit on hit_valid&hit_ready, both at posedge.
  assign job_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign hs_state   = hs_state_q;
  assign hs_data    = hs_data_q;
  assign hit_valid  = (fifo_count_q != '0);
  assign hit_nonce  = fifo_mem_q[rd_ptr_q];
  assign issued_cnt = issued_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jh512_nonce_scheduler.sv
// Bench for jh512_nonce_scheduler: behavioural hasher model, hit scoreboard with a separate
// monitor, directed corner jobs, randomized jobs and a mid-job reset.
module tb_jh512_nonce_scheduler;

  localparam int L   = 96;
  localparam int NL  = 96;
  localparam int FD  = 4;
  localparam int TMO = 5000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1023:0] job_state = '0;
  logic [127:0]  job_data = '0;
  logic [31:0]   job_start = '0;
  logic [31:0]   job_end = '0;
  logic [63:0]   job_target = '0;
  logic          abort = 1'b0;
  logic [1023:0] hs_state;
  logic [127:0]  hs_data;
  logic [511:0]  hs_hash;
  logic          hit_valid;
  logic          hit_ready = 1'b1;
  logic [31:0]   hit_nonce;
  logic          busy;
  logic          done;
  logic [31:0]   issued_cnt;
  logic [1:0]    dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q [$];
  logic        ready_force = 1'b1;
  logic        rand_mode = 1'b0;
  logic        zero_en = 1'b0;
  logic [31:0] zero_nonce = '0;
  logic [31:0] pipe [L-1];

  jh512_nonce_scheduler #(.HASH_LATENCY(L), .NONCE_LSB(NL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_state(job_state), .job_data(job_data), .job_start(job_start), .job_end(job_end),
    .job_target(job_target), .abort(abort), .hs_state(hs_state), .hs_data(hs_data),
    .hs_hash(hs_hash), .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_nonce(hit_nonce),
    .busy(busy), .done(done), .issued_cnt(issued_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Hasher stand-in: the hs_data register is the first of L stages, L-1 more follow here.
  function automatic logic [63:0] model_hash(input logic [31:0] n, input logic ze,
                                             input logic [31:0] zn);
    if (ze && n == zn) return 64'h0;
    return {n ^ 32'h5bd1e995, (n * 32'h9e3779b1) | 32'h1};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= hs_data[NL +: 32];
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end

  assign hs_hash = {{14{pipe[L-2]}}, model_hash(pipe[L-2], zero_en, zero_nonce)};

  initial begin
    forever begin
      @(posedge clk);
      #1;
      hit_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && hit_valid && hit_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_hit: got nonce %0h, expected none", hit_nonce);
      end else begin
        check("hit_nonce", hit_nonce, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [63:0] tgt,
                         input int abort_k, input int stall, input int exp_lat);
    logic [1023:0] js;
    logic [127:0]  jd;
    logic [127:0]  exp_data;
    longint        n_issue;
    int            cyc;
    int            base;
    int            w;
    for (int i = 0; i < 32; i++) js[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) jd[i*32 +: 32] = $urandom;
    if (stall > 0) ready_force = 1'b0;
    w = 0;
    while ((!job_ready || hit_valid) && w < TMO) begin
      cycles(1);
      w++;
    end
    if (w >= TMO) fail_now("idle_wait");
    n_issue = (s > e) ? 64'd1 : longint'(e) - longint'(s) + 1;
    if (abort_k >= 0) begin
      if (n_issue > abort_k + 1) n_issue = abort_k + 1;
      if (n_issue > FD) n_issue = FD;
    end
    for (longint j = 0; j < n_issue; j++) begin
      if (model_hash(s + 32'(j), zero_en, zero_nonce) <= tgt) exp_q.push_back(s + 32'(j));
    end
    job_valid  = 1'b1;
    job_state  = js;
    job_data   = jd;
    job_start  = s;
    job_end    = e;
    job_target = tgt;
    cycles(1);
    job_valid = 1'b0;
    base = done_cnt;
    cyc = 0;
    check("hs_state_latched", 128'(hs_state == js), 128'd1);
    exp_data = jd;
    exp_data[NL +: 32] = s;
    while (!done && cyc < TMO) begin
      if (cyc == 1) check("hs_data_first", hs_data, exp_data);
      abort = (cyc == abort_k);
      if (stall > 0 && cyc == stall) begin
        check("stall_issued", issued_cnt, (n_issue < FD) ? n_issue : FD);
        check("stall_hit_valid", hit_valid, 1);
        ready_force = 1'b1;
      end
      cycles(1);
      cyc++;
    end
    abort = 1'b0;
    if (cyc >= TMO) fail_now("done_wait");
    if (exp_lat > 0) check("done_latency", cyc, exp_lat);
    check("issued_cnt", issued_cnt, n_issue);
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      cycles(1);
      w++;
    end
    check("hits_outstanding", exp_q.size(), 0);
    cycles(3);
    check("done_pulses", done_cnt - base, 1);
  endtask

  task automatic reset_mid_run();
    int w;
    ready_force = 1'b1;
    w = 0;
    while ((!job_ready || hit_valid) && w < TMO) begin
      cycles(1);
      w++;
    end
    for (int j = 0; j <= 1000; j++) exp_q.push_back(32'(j));
    job_valid  = 1'b1;
    job_start  = 32'd0;
    job_end    = 32'd1000;
    job_target = '1;
    cycles(1);
    job_valid = 1'b0;
    cycles(L + 30);
    ready_force = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("rst_job_ready", job_ready, 1);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_issued_cnt", issued_cnt, 0);
    exp_q.delete();
    ready_force = 1'b1;
    cycles(L + 30);
    check("late_hit_valid", hit_valid, 0);
    check("late_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] e;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    check("reset_job_ready", job_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hit_valid", hit_valid, 0);
    check("reset_issued_cnt", issued_cnt, 0);
    check("reset_hs_data", hs_data, 0);
    check("reset_hs_state_zero", 128'(hs_state == '0), 128'd1);

    run_job(32'd5, 32'd8, '1, -1, 0, L + 4);

    zero_en = 1'b1;
    zero_nonce = 32'd7;
    run_job(32'd5, 32'd8, 64'd0, -1, 0, 0);
    zero_en = 1'b0;

    run_job(32'd0, 32'd9, '1, -1, 150, 0);
    run_job(32'hFFFFFFFF, 32'hFFFFFFFF, '1, -1, 0, 0);
    run_job(32'd20, 32'd10, '1, -1, 0, 0);
    run_job(32'd0, 32'd1000, '1, 3, 0, 0);

    rand_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
      e = s + 32'($urandom_range(0, 9));
      run_job(s, e, {$urandom, $urandom}, -1, 0, 0);
    end
    rand_mode = 1'b0;

    reset_mid_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
